// File: rtl/uart_rx_sample_ctrl.sv
// UART receive sequencer: start detection, mid-bit sampling, LSB-first assembly
// and stop-bit framing check, all advanced by the oversampling tick.
module uart_rx_sample_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t               state_reg, state_next;
  logic [TW-1:0]        tick_cnt_reg, tick_cnt_next;
  logic [BW-1:0]        bit_cnt_reg, bit_cnt_next;
  logic [DATA_BITS-1:0] data_sr_reg, data_sr_next;
  logic [DATA_BITS-1:0] rx_data_reg, rx_data_next;
  logic                 rx_valid_reg, rx_valid_next;
  logic                 frame_err_reg, frame_err_next;
  logic                 stop_sample;

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      tick_cnt_reg  <= '0;
      bit_cnt_reg   <= '0;
      data_sr_reg   <= '0;
      rx_data_reg   <= '0;
      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      tick_cnt_reg  <= tick_cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
      data_sr_reg   <= data_sr_next;
      rx_data_reg   <= rx_data_next;
      rx_valid_reg  <= rx_valid_next;
      frame_err_reg <= frame_err_next;
    end
  end

  // Next-state and datapath; nothing moves without a sample tick.
  always_comb begin
    state_next    = state_reg;
    tick_cnt_next = tick_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    data_sr_next  = data_sr_reg;
    if (sample_tick) begin
      case (state_reg)
        IDLE: begin
          if (!rx) begin
            state_next    = START;
            tick_cnt_next = '0;
          end
        end
        START: begin
          if (tick_cnt_reg == HALF_LAST) begin
            tick_cnt_next = '0;
            bit_cnt_next  = '0;
            state_next    = rx ? IDLE : DATA;
          end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt_reg == FULL_LAST) begin
            tick_cnt_next = '0;
            bit_cnt_next  = bit_cnt_reg + 1'b1;
            data_sr_next  = {rx, data_sr_reg[DATA_BITS-1:1]};
            if (bit_cnt_reg == LAST_BIT) state_next = STOP;
          end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
          end
        end
        STOP: begin
          if (tick_cnt_reg == FULL_LAST) begin
            tick_cnt_next = '0;
            state_next    = rx ? IDLE : BRK;
          end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
          end
        end
        BRK: begin
          // Hold here until the line returns high so a break cannot look like a start.
          if (rx) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Output decode: pulses derive from the stop-bit sample.
  always_comb begin
    stop_sample    = sample_tick && (state_reg == STOP) && (tick_cnt_reg == FULL_LAST);
    rx_valid_next  = stop_sample && rx;
    frame_err_next = stop_sample && !rx;
    rx_data_next   = rx_valid_next ? data_sr_reg : rx_data_reg;
    busy           = (state_reg != IDLE);
  end

  assign rx_data   = rx_data_reg;
  assign rx_valid  = rx_valid_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_uart_rx_sample_ctrl.sv
// Directed bench for uart_rx_sample_ctrl: frames are queued as expectations when
// sent and checked by a monitor when rx_valid/frame_err pulse.
module tb_uart_rx_sample_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int   vectors = 0;
  int   miscompares = 0;
  bit   tick_en = 1'b1;
  int   div = 0;
  logic [7:0] last_good = 8'h00;

  typedef struct {
    bit         err;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];

  uart_rx_sample_ctrl #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk(clk),
    .rst(rst),
    .sample_tick(sample_tick),
    .rx(rx),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .frame_err(frame_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // One tick every 4 clk; freezable without losing phase.
  initial begin
    forever begin
      @(negedge clk);
      if (tick_en) begin
        div = (div + 1) % 4;
        sample_tick = (div == 0);
      end else begin
        sample_tick = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (!sample_tick);
    end
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input bit stop_bit);
    exp_t e;
    e.err  = !stop_bit;
    e.data = stop_bit ? data : last_good;
    sb.push_back(e);
    if (stop_bit) last_good = data;
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      wait_ticks(16);
    end
    rx = stop_bit;
    wait_ticks(16);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    int   tick_no = 0;
    int   start_tick = 0;
    bit   busy_prev = 1'b0;
    bit   valid_prev = 1'b0;
    bit   err_prev = 1'b0;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sample_tick) tick_no++;
      if (busy && !busy_prev) start_tick = tick_no;
      if (rx_valid || frame_err) begin
        check("pulse_exclusive", 32'(rx_valid & frame_err), 0);
        check("pulse_width", 32'((rx_valid & valid_prev) | (frame_err & err_prev)), 0);
        if (sb.size() == 0) begin
          check("unexpected_pulse", 32'(rx_valid), 32'(1'b0));
        end else begin
          e = sb.pop_front();
          check("frame_err", 32'(frame_err), 32'(e.err));
          check("rx_valid", 32'(rx_valid), 32'(!e.err));
          check("rx_data", 32'(rx_data), 32'(e.data));
          check("latency_ticks", 32'(tick_no - start_tick), 152);
        end
        $display("frame done: rx_data=%02h valid=%0b ferr=%0b t=%0t", rx_data, rx_valid, frame_err, $time);
      end
      busy_prev  = busy;
      valid_prev = rx_valid;
      err_prev   = frame_err;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, miscompares %0d", miscompares);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_rx_data", 32'(rx_data), 0);
    check("reset_rx_valid", 32'(rx_valid), 0);
    check("reset_frame_err", 32'(frame_err), 0);
    check("reset_busy", 32'(busy), 0);
    rst = 1'b0;
    wait_ticks(4);

    // Clean frame 0xA5
    send_frame(8'hA5, 1'b1);
    rx = 1'b1;
    wait_ticks(20);
    check("a5_busy_after", 32'(busy), 0);
    check("a5_rx_data", 32'(rx_data), 32'h A5);
    check("a5_sb_empty", 32'(sb.size()), 0);

    // Glitch: low for 4 ticks, rejected at start-bit centre
    rx = 1'b0;
    wait_ticks(1);
    check("glitch_busy_rise", 32'(busy), 1);
    wait_ticks(3);
    rx = 1'b1;
    wait_ticks(4);
    check("glitch_busy_tick7", 32'(busy), 1);
    wait_ticks(1);
    check("glitch_busy_tick8", 32'(busy), 0);
    wait_ticks(20);
    check("glitch_rx_data", 32'(rx_data), 32'h A5);

    // Good frame, then bad stop bit with the line held low (break)
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b0);
    wait_ticks(30);
    check("break_busy_held", 32'(busy), 1);
    check("break_rx_data", 32'(rx_data), 32'h A5);
    rx = 1'b1;
    wait_ticks(1);
    check("break_busy_release", 32'(busy), 0);
    wait_ticks(20);
    check("break_sb_empty", 32'(sb.size()), 0);

    // Back-to-back frames with no idle gap
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    rx = 1'b1;
    wait_ticks(20);
    check("b2b_rx_data", 32'(rx_data), 32'h FF);
    check("b2b_sb_empty", 32'(sb.size()), 0);

    // Reset during data bit 4; partial frame discarded
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      rx = (8'h96 >> i) & 1'b1;
      wait_ticks(16);
    end
    rx = 1'b1;
    wait_ticks(8);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_rx_data", 32'(rx_data), 0);
    check("midrst_rx_valid", 32'(rx_valid), 0);
    check("midrst_frame_err", 32'(frame_err), 0);
    check("midrst_busy", 32'(busy), 0);
    last_good = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_ticks(20);
    send_frame(8'h5A, 1'b1);
    rx = 1'b1;
    wait_ticks(20);
    check("postrst_rx_data", 32'(rx_data), 32'h 5A);

    // Freeze ticks for 100 clk mid-frame
    fork
      send_frame(8'hC3, 1'b1);
      begin
        wait_ticks(70);
        tick_en = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("freeze_busy", 32'(busy), 1);
        check("freeze_rx_data", 32'(rx_data), 32'h 5A);
        tick_en = 1'b1;
      end
    join
    rx = 1'b1;
    wait_ticks(20);
    check("freeze_done_rx_data", 32'(rx_data), 32'h C3);
    check("final_sb_empty", 32'(sb.size()), 0);
    check("final_busy", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
